// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared state encodings, defaults and pointer helper for the
//               I2C request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    localparam logic [3:0] ARB_IDLE   = 4'b0001;
    localparam logic [3:0] ARB_LAUNCH = 4'b0010;
    localparam logic [3:0] ARB_BUSY   = 4'b0100;
    localparam logic [3:0] ARB_DONE   = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE   = ARB_IDLE,
        ST_LAUNCH = ARB_LAUNCH,
        ST_BUSY   = ARB_BUSY,
        ST_DONE   = ARB_DONE
    } arb_state_t;

    // Successor of a requester index, wrapping at num_req.
    function automatic int unsigned next_ptr(input int unsigned idx,
                                             input int unsigned num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_req_arbiter_if.sv
// ============================================================================
// Module      : i2c_req_arbiter_if
// Description : Requester-side and master-side signals of the I2C arbiter.
//               slave = arbiter view, master = client/master-model view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_req_arbiter_if
    import i2c_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_slv_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_reg_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            err;
    logic                          mst_wr_en;
    logic [DATA_WIDTH-1:0]         mst_slv_addr;
    logic [DATA_WIDTH-1:0]         mst_reg_addr;
    logic [DATA_WIDTH-1:0]         mst_data;
    logic                          mst_busy;

    modport slave (
        input  req, req_slv_addr, req_reg_addr, req_data, mst_busy,
        output gnt, done, err, mst_wr_en, mst_slv_addr, mst_reg_addr, mst_data
    );

    modport master (
        output req, req_slv_addr, req_reg_addr, req_data, mst_busy,
        input  gnt, done, err, mst_wr_en, mst_slv_addr, mst_reg_addr, mst_data
    );

endinterface

`default_nettype wire

// File: rtl/i2c_rr_pick.sv
// ============================================================================
// Module      : i2c_rr_pick
// Description : Combinational round-robin picker; first set request at or
//               after i_ptr (wrapping) wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [PTR_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_win,
    output logic                    o_valid
);

    always_comb begin
        int unsigned w_idx;
        o_win   = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            w_idx = (32'(i_ptr) + off) % NUM_REQ;
            if (!o_valid && i_req[w_idx]) begin
                o_win[w_idx] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
// ============================================================================
// Module      : i2c_req_arbiter
// Description : Round-robin arbiter/sequencer sharing one I2C master among
//               NUM_REQ requesters. Optional wait timeout: I2C_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 1024
) (
    input  wire logic         clk,
    input  wire logic         rst,
    i2c_req_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        r_owner;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [DATA_WIDTH-1:0]   r_slv_addr;
    logic [DATA_WIDTH-1:0]   r_reg_addr;
    logic [DATA_WIDTH-1:0]   r_data;

    logic [NUM_REQ-1:0]      w_win;
    logic                    w_win_vld;
    logic [PTR_W-1:0]        w_win_idx;
    logic [DATA_WIDTH-1:0]   w_slv_addr;
    logic [DATA_WIDTH-1:0]   w_reg_addr;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    w_capture;
    logic                    w_cnt_exp;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_win_vld)
    );

    // Winner index and its field slices, selected by the one-hot winner.
    always_comb begin
        w_win_idx  = '0;
        w_slv_addr = '0;
        w_reg_addr = '0;
        w_data     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx  = PTR_W'(i);
                w_slv_addr = bus.req_slv_addr[i*DATA_WIDTH +: DATA_WIDTH];
                w_reg_addr = bus.req_reg_addr[i*DATA_WIDTH +: DATA_WIDTH];
                w_data     = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (bus.mst_busy)
                    w_state_nxt = ST_BUSY;
                else if (w_cnt_exp)
                    w_state_nxt = ST_DONE;
            end
            ST_BUSY: begin
                if (!bus.mst_busy || w_cnt_exp)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_gnt      <= '0;
            r_slv_addr <= '0;
            r_reg_addr <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_gnt      <= w_win;
                r_owner    <= w_win_idx;
                r_slv_addr <= w_slv_addr;
                r_reg_addr <= w_reg_addr;
                r_data     <= w_data;
            end
            if (r_state == ST_DONE) begin
                r_gnt <= '0;
                r_ptr <= PTR_W'(next_ptr(32'(r_owner), NUM_REQ));
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_timeout;

    assign w_cnt_exp = (r_cnt == CNT_W'(TIMEOUT - 1));
    // Expiry only counts when the normal exit condition is absent this cycle.
    assign w_timeout = w_cnt_exp &&
                       (((r_state == ST_LAUNCH) && !bus.mst_busy) ||
                        ((r_state == ST_BUSY)   &&  bus.mst_busy));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if ((r_state == ST_LAUNCH) || (r_state == ST_BUSY))
                r_cnt <= r_cnt + 1'b1;
            r_err <= w_timeout;
        end
    end

    assign bus.err = ((r_state == ST_DONE) && r_err) ? r_gnt : '0;
`else
    assign w_cnt_exp = 1'b0;
    assign bus.err   = '0;
`endif

    assign bus.gnt          = r_gnt;
    assign bus.done         = (r_state == ST_DONE) ? r_gnt : '0;
    assign bus.mst_wr_en    = (r_state == ST_LAUNCH);
    assign bus.mst_slv_addr = r_slv_addr;
    assign bus.mst_reg_addr = r_reg_addr;
    assign bus.mst_data     = r_data;

endmodule

`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
// ============================================================================
// Module      : tb_i2c_req_arbiter
// Description : Directed self-checking bench for i2c_req_arbiter
//               (timeout case active when I2C_ARB_TIMEOUT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    i2c_req_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    i2c_req_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .TIMEOUT    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fld(input int i, input logic [7:0] slv, input logic [7:0] ra, input logic [7:0] dat);
        bus.req_slv_addr[i*DW +: DW] = slv;
        bus.req_reg_addr[i*DW +: DW] = ra;
        bus.req_data[i*DW +: DW]     = dat;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.mst_busy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        for (int i = 0; i < 20; i++) begin
            if (bus.gnt != 4'b0000) break;
            tick();
        end
        g = bus.gnt;
        if (g == 4'b0000) check("gnt_wait", 32'(g), 32'h1);
    endtask

    // Serve whoever is granted; clear drop bits from req once in BUSY.
    task automatic run_txn(output logic [3:0] g, input logic [3:0] drop);
        wait_gnt(g);
        bus.mst_busy = 1'b1;
        tick();
        check("wr_en_low_in_busy", 32'(bus.mst_wr_en), 32'h0);
        bus.req = bus.req & ~drop;
        tick();
        bus.mst_busy = 1'b0;
        tick();
        check("done_pulse", 32'(bus.done), 32'(g));
        check("err_clear", 32'(bus.err), 32'h0);
        tick();
        check("idle_gap_gnt", 32'(bus.gnt), 32'h0);
        check("done_one_cycle", 32'(bus.done), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        logic [3:0] exp_order [5];
        logic       saw;

        bus.req = '0;
        bus.req_slv_addr = '0;
        bus.req_reg_addr = '0;
        bus.req_data = '0;
        bus.mst_busy = 1'b0;

        // Reset state
        do_reset();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_wr_en", 32'(bus.mst_wr_en), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_fields", {8'h0, bus.mst_slv_addr, bus.mst_reg_addr, bus.mst_data}, 32'h0);

        // Single request from requester 2
        set_fld(2, 8'h50, 8'h10, 8'hA5);
        bus.req = 4'b0100;
        tick();
        check("single_gnt", 32'(bus.gnt), 32'h4);
        check("single_wr_en", 32'(bus.mst_wr_en), 32'h1);
        check("single_fields", {8'h0, bus.mst_slv_addr, bus.mst_reg_addr, bus.mst_data}, 32'h005010A5);
        bus.mst_busy = 1'b1;
        tick();
        check("single_wr_en_drop", 32'(bus.mst_wr_en), 32'h0);
        tick();
        bus.mst_busy = 1'b0;
        bus.req = 4'b0000;
        tick();
        check("single_done", 32'(bus.done), 32'h4);
        tick();
        check("single_done_1cyc", 32'(bus.done), 32'h0);
        check("single_gnt_clr", 32'(bus.gnt), 32'h0);

        // Fairness with all four requesting
        do_reset();
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_txn(g, 4'b0000);
            check($sformatf("fair_order_%0d", i), 32'(g), 32'(exp_order[i]));
        end
        bus.req = 4'b0000;

        // Early drop: requester 1 leaves while 0 is being served
        do_reset();
        bus.req = 4'b1011;
        run_txn(g, 4'b0011);
        check("drop_first", 32'(g), 32'h1);
        wait_gnt(g);
        check("drop_next_is_3", 32'(g), 32'h8);
        bus.req = 4'b0000;
        run_txn(g, 4'b0000);

        // Field stability after grant
        do_reset();
        set_fld(0, 8'h50, 8'h10, 8'hA5);
        bus.req = 4'b0001;
        wait_gnt(g);
        bus.req_data[7:0] = 8'h3C;
        bus.req = 4'b0000;
        check("stab_launch", 32'(bus.mst_data), 32'hA5);
        bus.mst_busy = 1'b1;
        tick();
        check("stab_busy", 32'(bus.mst_data), 32'hA5);
        bus.mst_busy = 1'b0;
        tick();
        check("stab_done_pulse", 32'(bus.done), 32'h1);
        check("stab_done", 32'(bus.mst_data), 32'hA5);
        tick();

        // Stalled master: busy never rises in LAUNCH
        do_reset();
        bus.req = 4'b0001;
        wait_gnt(g);
        bus.req = 4'b0000;
        saw = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        for (int i = 1; i < 16; i++) begin
            tick();
            if (bus.done != 4'b0000) saw = 1'b1;
        end
        check("to_no_early_done", 32'(saw), 32'h0);
        tick();
        check("to_done", 32'(bus.done), 32'h1);
        check("to_err", 32'(bus.err), 32'h1);
        check("to_wr_en", 32'(bus.mst_wr_en), 32'h0);
        tick();
        bus.req = 4'b0010;
        run_txn(g, 4'b0010);
        check("to_recover", 32'(g), 32'h2);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done != 4'b0000 || bus.mst_wr_en != 1'b1) saw = 1'b1;
        end
        check("stall_waits", 32'(saw), 32'h0);
        bus.mst_busy = 1'b1;
        tick();
        bus.mst_busy = 1'b0;
        tick();
        check("stall_done", 32'(bus.done), 32'h1);
        tick();
`endif

        // Async reset in BUSY; ptr=1 beforehand so the restart winner shows ptr cleared
        do_reset();
        bus.req = 4'b0001;
        run_txn(g, 4'b0001);
        bus.req = 4'b1000;
        wait_gnt(g);
        check("ar_pre_gnt", 32'(g), 32'h8);
        bus.mst_busy = 1'b1;
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("ar_gnt_now", 32'(bus.gnt), 32'h0);
        check("ar_wr_en_now", 32'(bus.mst_wr_en), 32'h0);
        check("ar_done_now", 32'(bus.done), 32'h0);
        tick();
        rst = 1'b0;
        bus.mst_busy = 1'b0;
        bus.req = 4'b0011;
        check("ar_no_done", 32'(bus.done), 32'h0);
        tick();
        check("ar_winner_0", 32'(bus.gnt), 32'h1);
        check("ar_no_done2", 32'(bus.done), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
